// File: rtl/cpu_intr_pkg.sv
// Shared definitions for the CPU interrupt sources: keyboard interrupt
// generator state encoding and the scancode width.
package cpu_intr_pkg;

    localparam int unsigned KIG_CODE_W = 8;

    typedef enum logic [1:0] {
        KIG_IDLE      = 2'b00,
        KIG_PULSE     = 2'b01,
        KIG_WAIT_ACK  = 2'b10,
        KIG_WAIT_DONE = 2'b11
    } kig_state_e;

endpackage

// File: rtl/keyboard_intr_gen_if.sv
// Signal bundle between the keyboard front end / trap handler and the
// keyboard interrupt source. master = interrupt source, slave = its environment.
interface keyboard_intr_gen_if #(
    parameter int unsigned DEPTH = 4
) ();
    import cpu_intr_pkg::*;

    localparam int unsigned CNT_BITS = $clog2(DEPTH + 1);

    logic                  key_valid;
    logic [KIG_CODE_W-1:0] key_code;
    logic                  intr_enable;
    logic                  intr_ack;
    logic                  isr_done;
    logic                  clr_overflow;
    logic                  keyboard_intr;
    logic [KIG_CODE_W-1:0] keyboard_data;
    logic [CNT_BITS-1:0]   fifo_count;
    logic                  overflow;
    logic                  busy;

    modport master (
        input  key_valid, key_code, intr_enable, intr_ack, isr_done, clr_overflow,
        output keyboard_intr, keyboard_data, fifo_count, overflow, busy
    );

    modport slave (
        output key_valid, key_code, intr_enable, intr_ack, isr_done, clr_overflow,
        input  keyboard_intr, keyboard_data, fifo_count, overflow, busy
    );

endinterface

// File: rtl/kbd_code_fifo.sv
// Scancode circular buffer with show-ahead head output. A push while full is
// accepted only when a pop happens in the same cycle.
module kbd_code_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic [WIDTH-1:0]             din_i,
    output logic [WIDTH-1:0]             dout_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         full_o,
    output logic                         empty_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);
    assign dout_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Power-of-two depth: pointers wrap by natural overflow.
        if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/keyboard_intr_gen.sv
// Keyboard interrupt source: queues scancodes and issues them one at a time
// as a single-cycle interrupt, re-issuing if the trap handler does not ack.
module keyboard_intr_gen
    import cpu_intr_pkg::*;
#(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned ACK_TIMEOUT = 255,
    parameter int unsigned CNT_W       = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    keyboard_intr_gen_if.master bus
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    kig_state_e            state_q, state_d;
    logic [CNT_W-1:0]      tmo_q, tmo_d;
    logic                  intr_q;
    logic [KIG_CODE_W-1:0] data_q;
    logic                  ovf_q;

    logic                  pop;
    logic                  tmo_hit;
    logic                  drop;
    logic [KIG_CODE_W-1:0] head;
    logic [CW-1:0]         count;
    logic                  full, empty;

    kbd_code_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (KIG_CODE_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (bus.key_valid),
        .pop_i   (pop),
        .din_i   (bus.key_code),
        .dout_o  (head),
        .count_o (count),
        .full_o  (full),
        .empty_o (empty)
    );

    assign tmo_hit = (tmo_q == CNT_W'(ACK_TIMEOUT));
    assign drop    = bus.key_valid && full && !pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= KIG_IDLE;
        else        state_q <= state_d;
    end

    // intr_ack wins over a simultaneous isr_done because isr_done is only
    // looked at once WAIT_DONE has been reached.
    always_comb begin
        state_d = state_q;
        case (state_q)
            KIG_IDLE:      if (!empty && bus.intr_enable) state_d = KIG_PULSE;
            KIG_PULSE:     state_d = KIG_WAIT_ACK;
            KIG_WAIT_ACK: begin
                if (bus.intr_ack)  state_d = KIG_WAIT_DONE;
                else if (tmo_hit)  state_d = KIG_PULSE;
            end
            KIG_WAIT_DONE: if (bus.isr_done) state_d = KIG_IDLE;
            default:       state_d = KIG_IDLE;
        endcase
    end

    always_comb begin
        pop   = 1'b0;
        tmo_d = tmo_q;
        case (state_q)
            KIG_IDLE:     pop = !empty && bus.intr_enable;
            KIG_PULSE:    tmo_d = '0;
            KIG_WAIT_ACK: if (!bus.intr_ack && !tmo_hit) tmo_d = tmo_q + CNT_W'(1);
            default:      ;
        endcase
    end

    // The interrupt line is a register of "was in PULSE", so it follows the
    // PULSE state by one cycle and can never be high two cycles in a row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q  <= '0;
            intr_q <= 1'b0;
            data_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            tmo_q  <= tmo_d;
            intr_q <= (state_q == KIG_PULSE);
            if (pop) data_q <= head;
            if (drop)                  ovf_q <= 1'b1;
            else if (bus.clr_overflow) ovf_q <= 1'b0;
        end
    end

    assign bus.keyboard_intr = intr_q;
    assign bus.keyboard_data = data_q;
    assign bus.fifo_count    = count;
    assign bus.overflow      = ovf_q;
    assign bus.busy          = (state_q != KIG_IDLE);

endmodule
